lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Receiving end of the HD44780-style character LCD bus that the mini CPU drives (lcd_data/lcd_rs/lcd_rw/lcd_enable/lcd_on).
- Samples the bus and decodes each enable strobe into a command write, data write or read.
- Keeps a 2x16 shadow of display memory, the address counter, the display-on flag and a modelled busy flag.
- Answers status and data reads. Used as an on-board display mirror and as the bench's LCD model.

Parameters:
SYNC_STAGES, 2, synchronizer depth on all bus inputs (>=2)
BUSY_CYCLES, 2000, busy duration after a normal command/data write (40 us at 50 MHz)
CLEAR_BUSY_CYCLES, 82000, busy duration after clear/return-home (1.64 ms)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
lcd_data  in  8  bus data from initiator
lcd_rs  in  1  0 = command/status, 1 = data
lcd_rw  in  1  0 = write, 1 = read
lcd_enable  in  1  strobe; transfer latched on falling edge
lcd_on  in  1  module power; 0 holds responder idle
lcd_rdata  out  8  read-back byte: status {busy, addr[6:0]} or data
ev_valid  out  1  one-cycle pulse per decoded transfer
ev_rs  out  1  rs of the transfer
ev_rw  out  1  rw of the transfer
ev_byte  out  8  data written, or data returned for reads
busy  out  1  modelled busy flag
addr  out  7  DDRAM address counter
disp_on  out  1  display-control D bit
rd_idx  in  5  shadow read index (0-15 line 1, 16-31 line 2)
rd_char  out  8  shadow char at rd_idx, registered, 1-cycle latency
proto_err  out  1  sticky: write received while busy

Behaviour:
- Input path: all five bus inputs pass through SYNC_STAGES flops, then one edge-detect flop. A falling edge of synced enable while synced lcd_on=1 is a transfer. rs/rw/data are captured from the same synced sample.
- ev_valid pulses SYNC_STAGES+1 cycles after the first clk edge that samples lcd_enable low at the pin.
- Reset values: lcd_rdata 0, ev_* 0, busy 1, addr 0, disp_on 0, proto_err 0, rd_char 0x20, increment mode I/D=1.
- After reset the FSM enters CLEARING.
- FSM states:
  - CLEARING: writes 0x20 to shadow index 0..31, one per cycle (32 cycles), then enters BUSY with count CLEAR_BUSY_CYCLES.
  - BUSY: counter decrements to 0, then enters IDLE. busy=1 in CLEARING and BUSY; busy=0 only in IDLE.
- Commands (rs=0, rw=0):
  - 0x01 clear: addr=0, I/D=1, enter CLEARING.
  - 0x02-0x03 return home: addr=0, BUSY with CLEAR_BUSY_CYCLES.
  - 0x04-0x07 entry mode: I/D=data[1].
  - 0x08-0x0F display control: disp_on=data[2].
  - 0x10-0x1F shift: if data[3]=0, cursor moves right if data[2]=1, else left (same step rules as data writes); if data[3]=1, no change.
  - 0x20-0x7F function set / CGRAM: no state change.
  - 0x80-0xFF set address: addr=data[6:0].
  - Every command except clear/home enters BUSY with BUSY_CYCLES.
  - 0x00: no-op with no busy.
- Data write (rs=1, rw=0):
  - addr 0x00-0x0F writes index addr; 0x40-0x4F writes index 16+addr[3:0]; other addresses are not stored.
  - Then addr steps and BUSY is entered with BUSY_CYCLES.
- Address step:
  - Increment: 0x27->0x40, 0x67->0x00, otherwise +1.
  - Decrement: 0x00->0x67, 0x40->0x27, otherwise -1.
  - An addr value outside 0x00-0x27/0x40-0x67 (via set-address) steps by plain ±1 mod 128.
- Reads:
  - While synced rw=1 and rs=0, lcd_rdata = {busy, addr} combinationally from registers.
  - While rs=1, lcd_rdata = shadow char at addr, or 0x20 if unmapped.
  - On the falling edge of a data read: addr steps; no busy.
  - Reads never set proto_err and are legal while busy.
- Write while busy, or during CLEARING: proto_err is set (sticky until reset). The write is discarded with no state change. ev_valid still pulses.
- lcd_on=0: transfers ignored; current FSM state continues.
- rst_n low mid-clear or mid-busy: immediate return to reset values, then a fresh CLEARING.

Test Plan:
1. Release reset, wait 32+CLEAR_BUSY_CYCLES -> busy falls to 0; rd_char=0x20 for all 32 indices; addr=0.
2. Write data 0x41,0x42 with waits > BUSY_CYCLES -> rd_idx 0/1 give 0x41/0x42; addr=0x02; two ev_valid pulses with ev_rs=1.
3. Command 0xA7 (addr 0x27), write 0x5A -> 0x5A not stored; addr=0x40; next write 0x31 -> rd_idx 16 = 0x31.
4. Command 0x04 (decrement), 0x80, write 0x58 -> index 0 = 0x58; addr=0x67.
5. Command 0x0C, then a second write before BUSY_CYCLES elapse -> disp_on=1, proto_err=1, second write has no effect; status read during busy returns lcd_rdata[7]=1.
6. Assert rst_n low during CLEARING after command 0x01 -> outputs at reset values; busy=1; full clear re-runs; proto_err=0.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// Receiving end of the HD44780-style character LCD bus: decodes enable strobes,
// keeps a 2x16 display shadow, address counter, display-on flag and modelled busy flag.
module lcd_bus_responder #(
    parameter int SYNC_STAGES       = 2,
    parameter int BUSY_CYCLES       = 2000,
    parameter int CLEAR_BUSY_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_enable,
    input  logic       lcd_on,
    output logic [7:0] lcd_rdata,
    output logic       ev_valid,
    output logic       ev_rs,
    output logic       ev_rw,
    output logic [7:0] ev_byte,
    output logic       busy,
    output logic [6:0] addr,
    output logic       disp_on,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic       proto_err
);
    localparam int CNT_W = $clog2(CLEAR_BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_BUSY_CYCLES);

    typedef enum logic [1:0] {ST_CLEARING, ST_BUSY, ST_IDLE} state_t;

    // Bus sample layout: {on, enable, rw, rs, data[7:0]}
    logic [11:0] sync_q [SYNC_STAGES];
    logic        on_s, en_s, rw_s, rs_s;
    logic [7:0]  data_s;

    logic        en_prev_q, xfer_q, x_rs_q, x_rw_q;
    logic [7:0]  x_data_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       clr_idx_q, clr_idx_d;
    logic [6:0]       addr_q, addr_d;
    logic             inc_q, inc_d;
    logic             disp_on_q, disp_on_d;
    logic             perr_q, perr_d;
    logic             ev_valid_d, ev_rs_d, ev_rw_d;
    logic [7:0]       ev_byte_d;

    logic [7:0] shadow [32];
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_char;
    logic [5:0] cur_map;
    logic [7:0] cur_char;
    logic       busy_w;

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Returns {hit, shadow index}; only the first 16 columns of each line are mirrored.
    function automatic logic [5:0] map_addr(input logic [6:0] a);
        logic [5:0] r;
        if (a[6:4] == 3'b000)      r = {2'b10, a[3:0]};
        else if (a[6:4] == 3'b100) r = {2'b11, a[3:0]};
        else                       r = 6'd0;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {lcd_on, lcd_enable, lcd_rw, lcd_rs, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign on_s   = sync_q[SYNC_STAGES-1][11];
    assign en_s   = sync_q[SYNC_STAGES-1][10];
    assign rw_s   = sync_q[SYNC_STAGES-1][9];
    assign rs_s   = sync_q[SYNC_STAGES-1][8];
    assign data_s = sync_q[SYNC_STAGES-1][7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev_q <= 1'b0;
            xfer_q    <= 1'b0;
            x_rs_q    <= 1'b0;
            x_rw_q    <= 1'b0;
            x_data_q  <= 8'h00;
        end else begin
            en_prev_q <= en_s;
            xfer_q    <= en_prev_q & ~en_s & on_s;
            x_rs_q    <= rs_s;
            x_rw_q    <= rw_s;
            x_data_q  <= data_s;
        end
    end

    assign busy_w   = (state_q != ST_IDLE);
    assign cur_map  = map_addr(addr_q);
    assign cur_char = cur_map[5] ? shadow[cur_map[4:0]] : 8'h20;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_idx_d  = clr_idx_q;
        addr_d     = addr_q;
        inc_d      = inc_q;
        disp_on_d  = disp_on_q;
        perr_d     = perr_q;
        ev_valid_d = 1'b0;
        ev_rs_d    = ev_rs;
        ev_rw_d    = ev_rw;
        ev_byte_d  = ev_byte;
        wr_en      = 1'b0;
        wr_idx     = clr_idx_q;
        wr_char    = 8'h20;

        case (state_q)
            ST_CLEARING: begin
                wr_en     = 1'b1;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d = ST_BUSY;
                    cnt_d   = CLEAR_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: ;
        endcase

        if (xfer_q) begin
            ev_valid_d = 1'b1;
            ev_rs_d    = x_rs_q;
            ev_rw_d    = x_rw_q;
            ev_byte_d  = x_rw_q ? (x_rs_q ? cur_char : {busy_w, addr_q}) : x_data_q;
            if (x_rw_q) begin
                if (x_rs_q) addr_d = step_addr(addr_q, inc_q);
            end else if (busy_w) begin
                // Writes that arrive while busy are dropped and flagged.
                perr_d = 1'b1;
            end else if (x_rs_q) begin
                wr_en   = cur_map[5];
                wr_idx  = cur_map[4:0];
                wr_char = x_data_q;
                addr_d  = step_addr(addr_q, inc_q);
                state_d = ST_BUSY;
                cnt_d   = BUSY_LOAD;
            end else begin
                casez (x_data_q)
                    8'b1???_????: begin
                        addr_d  = x_data_q[6:0];
                        state_d = ST_BUSY;
                        cnt_d   = BUSY_LOAD;
                    end
                    8'b01??_????, 8'b001?_????: begin
                        state_d = ST_BUSY;
                        cnt_d   = BUSY_LOAD;
                    end
                    8'b0001_????: begin
                        if (!x_data_q[3]) addr_d = step_addr(addr_q, x_data_q[2]);
                        state_d = ST_BUSY;
                        cnt_d   = BUSY_LOAD;
                    end
                    8'b0000_1???: begin
                        disp_on_d = x_data_q[2];
                        state_d   = ST_BUSY;
                        cnt_d     = BUSY_LOAD;
                    end
                    8'b0000_01??: begin
                        inc_d   = x_data_q[1];
                        state_d = ST_BUSY;
                        cnt_d   = BUSY_LOAD;
                    end
                    8'b0000_001?: begin
                        addr_d  = 7'h00;
                        state_d = ST_BUSY;
                        cnt_d   = CLEAR_LOAD;
                    end
                    8'b0000_0001: begin
                        addr_d    = 7'h00;
                        inc_d     = 1'b1;
                        clr_idx_d = 5'd0;
                        state_d   = ST_CLEARING;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEARING;
            cnt_q     <= '0;
            clr_idx_q <= 5'd0;
            addr_q    <= 7'h00;
            inc_q     <= 1'b1;
            disp_on_q <= 1'b0;
            perr_q    <= 1'b0;
            ev_valid  <= 1'b0;
            ev_rs     <= 1'b0;
            ev_rw     <= 1'b0;
            ev_byte   <= 8'h00;
            rd_char   <= 8'h20;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            addr_q    <= addr_d;
            inc_q     <= inc_d;
            disp_on_q <= disp_on_d;
            perr_q    <= perr_d;
            ev_valid  <= ev_valid_d;
            ev_rs     <= ev_rs_d;
            ev_rw     <= ev_rw_d;
            ev_byte   <= ev_byte_d;
            rd_char   <= shadow[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) shadow[wr_idx] <= wr_char;
    end

    always_comb begin
        lcd_rdata = 8'h00;
        if (rs_s)      lcd_rdata = cur_char;
        else if (rw_s) lcd_rdata = {busy_w, addr_q};
    end

    assign busy      = busy_w;
    assign addr      = addr_q;
    assign disp_on   = disp_on_q;
    assign proto_err = perr_q;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder with shortened busy timings.
`timescale 1ns/1ps
module tb_lcd_bus_responder;
    localparam int SYNC = 2;
    localparam int BUSYC = 20;
    localparam int CLRC = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_enable = 1'b0, lcd_on = 1'b1;
    logic [7:0] lcd_rdata, ev_byte, rd_char;
    logic       ev_valid, ev_rs, ev_rw, busy, disp_on, proto_err;
    logic [6:0] addr;
    logic [4:0] rd_idx = 5'd0;

    int total = 0;
    int bad = 0;
    logic [9:0] expq[$];
    logic [9:0] ev_exp;
    logic [7:0] ch;
    int         n;

    lcd_bus_responder #(
        .SYNC_STAGES(SYNC), .BUSY_CYCLES(BUSYC), .CLEAR_BUSY_CYCLES(CLRC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_enable(lcd_enable), .lcd_on(lcd_on), .lcd_rdata(lcd_rdata),
        .ev_valid(ev_valid), .ev_rs(ev_rs), .ev_rw(ev_rw), .ev_byte(ev_byte),
        .busy(busy), .addr(addr), .disp_on(disp_on), .rd_idx(rd_idx),
        .rd_char(rd_char), .proto_err(proto_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (ev_valid) begin
            if (expq.size() == 0) begin
                check("ev_unexpected", {22'd0, ev_rs, ev_rw, ev_byte}, 32'hFFFF_FFFF);
            end else begin
                ev_exp = expq.pop_front();
                check("ev", {22'd0, ev_rs, ev_rw, ev_byte}, {22'd0, ev_exp});
            end
        end
    end

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                        input logic [7:0] exp_byte, input bit expect_ev);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_enable = 1'b1;
        repeat (4) @(negedge clk);
        if (expect_ev) expq.push_back({rs, rw, exp_byte});
        lcd_enable = 1'b0;
        repeat (5) @(negedge clk);
        lcd_rw = 1'b0;
        check("ev_drained", expq.size(), 0);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic read_shadow(input logic [4:0] idx, output logic [7:0] c);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        c = rd_char;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_addr", addr, 0);
        check("rst_disp", disp_on, 0);
        check("rst_perr", proto_err, 0);
        check("rst_rdchar", rd_char, 8'h20);
        check("rst_evv", ev_valid, 0);
        check("rst_rdata", lcd_rdata, 0);
        rst_n = 1'b1;

        wait_idle(32 + CLRC + 50, n);
        check("clear_len_ok", n >= 32 + CLRC, 1);
        for (int i = 0; i < 32; i++) begin
            read_shadow(5'(i), ch);
            check("init_char", ch, 8'h20);
        end
        check("init_addr", addr, 0);

        xfer(1'b1, 1'b0, 8'h41, 8'h41, 1); wait_idle(100, n);
        xfer(1'b1, 1'b0, 8'h42, 8'h42, 1); wait_idle(100, n);
        read_shadow(5'd0, ch); check("wr_idx0", ch, 8'h41);
        read_shadow(5'd1, ch); check("wr_idx1", ch, 8'h42);
        check("addr_after2", addr, 7'h02);

        xfer(1'b0, 1'b0, 8'hA7, 8'hA7, 1); wait_idle(100, n);
        check("set_addr27", addr, 7'h27);
        xfer(1'b1, 1'b0, 8'h5A, 8'h5A, 1); wait_idle(100, n);
        check("wrap_27_40", addr, 7'h40);
        read_shadow(5'd15, ch); check("unmapped_nostore", ch, 8'h20);
        xfer(1'b1, 1'b0, 8'h31, 8'h31, 1); wait_idle(100, n);
        read_shadow(5'd16, ch); check("line2_idx16", ch, 8'h31);
        check("addr_41", addr, 7'h41);

        lcd_on = 1'b0;
        xfer(1'b1, 1'b0, 8'h99, 8'h00, 0);
        check("off_addr", addr, 7'h41);
        check("off_busy", busy, 0);
        read_shadow(5'd17, ch); check("off_nostore", ch, 8'h20);
        lcd_on = 1'b1;

        xfer(1'b0, 1'b0, 8'h04, 8'h04, 1); wait_idle(100, n);
        xfer(1'b0, 1'b0, 8'h80, 8'h80, 1); wait_idle(100, n);
        xfer(1'b1, 1'b0, 8'h58, 8'h58, 1); wait_idle(100, n);
        read_shadow(5'd0, ch); check("dec_idx0", ch, 8'h58);
        check("dec_wrap_67", addr, 7'h67);

        xfer(1'b0, 1'b0, 8'h0C, 8'h0C, 1);
        xfer(1'b1, 1'b0, 8'h77, 8'h77, 1);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b1;
        repeat (3) @(negedge clk);
        check("status_busy", lcd_rdata, 8'hE7);
        check("busy_during", busy, 1);
        lcd_rw = 1'b0;
        wait_idle(100, n);
        check("disp_on", disp_on, 1);
        check("proto_err", proto_err, 1);
        check("busy_wr_noeffect", addr, 7'h67);

        xfer(1'b0, 1'b0, 8'h80, 8'h80, 1); wait_idle(100, n);
        @(negedge clk);
        lcd_rs = 1'b1; lcd_rw = 1'b1;
        repeat (3) @(negedge clk);
        check("rdata_char", lcd_rdata, 8'h58);
        xfer(1'b1, 1'b1, 8'h00, 8'h58, 1);
        check("read_step", addr, 7'h67);
        check("read_nobusy", busy, 0);

        xfer(1'b0, 1'b0, 8'h01, 8'h01, 1);
        check("clear_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_busy", busy, 1);
        check("rst2_addr", addr, 0);
        check("rst2_disp", disp_on, 0);
        check("rst2_perr", proto_err, 0);
        check("rst2_rdchar", rd_char, 8'h20);
        check("rst2_evv", ev_valid, 0);
        rst_n = 1'b1;
        wait_idle(32 + CLRC + 50, n);
        check("clear2_len_ok", n >= 32 + CLRC, 1);
        read_shadow(5'd0, ch); check("recleared0", ch, 8'h20);
        read_shadow(5'd16, ch); check("recleared16", ch, 8'h20);
        check("post_perr", proto_err, 0);
        xfer(1'b1, 1'b0, 8'h61, 8'h61, 1); wait_idle(100, n);
        check("post_inc", addr, 7'h01);

        check("evq_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
